fifo_rd_ctrl: RTL
=================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter FIFO_W, 32, data word width; matches the width of the FIFO being drained.
REQ-002 Parameter BURST_W, 4, width of burst_len; a burst is 1..2**BURST_W words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one burst; sampled only in IDLE.
REQ-006 burst_len  input  BURST_W  words in the burst; 0 encodes 2**BURST_W; latched on accepted start.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_data  input  FIFO_W  FIFO read data, valid the cycle after the pop edge.
REQ-009 fifo_rd_en  output  1  FIFO pop strobe, combinational from registered state and fifo_empty.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  sink accepts the word when out_valid and out_ready are both high at a rising edge.
REQ-012 out_data  output  FIFO_W  head word of the skid buffer.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last word of the burst is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-016 IDLE -> READ on start; remaining = burst_len, with 0 mapped to 2**BURST_W, held in a BURST_W+1-bit counter.
REQ-017 READ -> DRAIN on the edge where the last pop is issued (remaining 1 -> 0).
REQ-018 DRAIN -> DONE on the edge where the last word is accepted at the output with no pop in flight.
REQ-019 DONE -> IDLE unconditionally after one cycle; done = 1 only in DONE.
REQ-020 fifo_rd_en = (state==READ) & !fifo_empty & (remaining!=0) & (cnt<2 | (cnt==2 & out_valid & out_ready)); cnt = buffered words + pops in flight.
REQ-021 Each pop SHALL decrement remaining by 1; the word is written into the skid buffer one cycle later.
REQ-022 The skid buffer SHALL be 2 entries deep, in-order; no word is dropped or duplicated; out_data is stable while out_valid & !out_ready.
REQ-023 Simultaneous buffer write and output accept SHALL keep the occupancy unchanged.
REQ-024 Minimum latency: pop at edge N, out_valid high after edge N+1; with out_ready high and fifo_empty low, throughput SHALL be 1 word per cycle.
REQ-025 When fifo_empty is high, no pop is issued; the FSM stays in READ indefinitely with no timeout.
REQ-026 start SHALL be ignored outside IDLE; start in DONE does not start a burst.
REQ-027 fifo_rd_en SHALL never assert in IDLE, DRAIN or DONE.

Reset
REQ-028 While reset_n is low, all of the following SHALL hold asynchronously: state = IDLE; remaining = 0; skid buffer empty; in-flight flag = 0.
REQ-029 While reset_n is low, the outputs SHALL be: fifo_rd_en = 0, out_valid = 0, out_data = 0, busy = 0, done = 0.
REQ-030 Reset mid-burst SHALL discard buffered and in-flight words; a FIFO pop issued on the edge coinciding with reset assertion is lost.
REQ-031 The first start is accepted at the first rising edge after reset_n deasserts.

Structure
REQ-032 The shared package fifo_pkg SHALL hold the FSM state enum (rd_state_t) and the FIFO_W default.
REQ-033 The skid buffer SHALL be the sub-module fifo_skid2 (2-entry valid/ready buffer, same clk/reset_n).
REQ-034 The FSM, counters and fifo_rd_en logic SHALL live in fifo_rd_ctrl.
REQ-035 Target size is 120-400 lines of RTL.

Verification
REQ-036 Basic burst: reset, preload FIFO 0x11..0x14, start with burst_len=4, out_ready=1 -> pops on 4 consecutive cycles; out_data 0x11,0x12,0x13,0x14 on consecutive cycles; done 1 cycle after the 0x14 accept.
REQ-037 Backpressure: burst_len=3, out_ready=0 for 5 cycles -> exactly 2 pops, out_data held at the first word; release -> remaining word popped, order preserved.
REQ-038 Empty stall: burst_len=2, FIFO empty for 6 cycles, then one word written -> no fifo_rd_en while empty; busy stays 1; exactly 1 word out, then stall resumes.
REQ-039 Wrap encoding: burst_len=0 with 20 words queued -> exactly 16 pops and 16 accepts; 4 words remain in the FIFO.
REQ-040 Reset mid-burst: assert reset_n=0 after 2 of 4 words -> outputs 0 immediately; after release, a new burst_len=2 returns the next FIFO words in order.
REQ-041 Ignored start: start held high throughout a burst_len=1 transfer -> a single burst; the next burst begins only from IDLE, and never from DONE.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read controller: FSM state encoding and default data width.
package fifo_pkg;

    localparam int unsigned FIFO_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } rd_state_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry in-order valid/ready buffer that absorbs words popped from the FIFO.
module fifo_skid2 #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem0_q, mem1_q;
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q;
    logic         accept;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = rd_ptr_q ? mem1_q : mem0_q;
    assign count     = count_q;
    assign accept    = out_valid & out_ready;

    // The controller never issues a write while the buffer is full without an accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (in_valid) begin
                if (wr_ptr_q) mem1_q <= in_data;
                else          mem0_q <= in_data;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (accept) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({in_valid, accept})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pops burst_len words from a FIFO and streams them out through
// a two-entry skid buffer with valid/ready handshake.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_W  = FIFO_W_DEF,
    parameter int unsigned BURST_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic              fifo_empty,
    input  logic [FIFO_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FIFO_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [BURST_W:0] RemOne  = {{BURST_W{1'b0}}, 1'b1};
    localparam logic [BURST_W:0] RemFull = {1'b1, {BURST_W{1'b0}}};

    rd_state_t        state_q;
    logic [BURST_W:0] remaining_q;
    logic             in_flight_q;
    logic             busy_q, done_q;

    logic [1:0] buf_count;
    logic [2:0] cnt;
    logic       accept;

    fifo_skid2 #(
        .W (FIFO_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_flight_q),
        .in_data   (fifo_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (buf_count)
    );

    // Words already buffered plus the one arriving from the FIFO this cycle.
    assign cnt    = {1'b0, buf_count} + {2'b00, in_flight_q};
    assign accept = out_valid & out_ready;

    always_comb begin
        fifo_rd_en = 1'b0;
        if (state_q == StRead && !fifo_empty && remaining_q != '0) begin
            fifo_rd_en = (cnt < 3'd2) || (cnt == 3'd2 && accept);
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        remaining_q <= (burst_len == '0) ? RemFull : {1'b0, burst_len};
                        state_q     <= StRead;
                        busy_q      <= 1'b1;
                    end
                end
                StRead: begin
                    if (fifo_rd_en) begin
                        remaining_q <= remaining_q - RemOne;
                        if (remaining_q == RemOne) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!in_flight_q && buf_count == 2'd1 && accept) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
